// File: rtl/core_pkg.sv
// Shared constants for the data-memory bridge: funct3 access codes,
// store size codes and the bridge FSM state encoding.
package core_pkg;

   // funct3 load/store size and sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size taken from funct3[1:0]; any other code is a word access
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// Simple req/ack data bus between the bridge (master) and memory (slave).
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb : master -> slave
//   bus_ack/bus_rdata                           : slave -> master, rdata valid with ack
interface dmem_bridge_if #(
   parameter int unsigned AW = 32
);
   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [31:0]   bus_wdata;
   logic [3:0]    bus_wstrb;
   logic          bus_ack;
   logic [31:0]   bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane helper for the bridge, purely combinational.
//   st_size/st_lo/st_data : store size, address[1:0] and LSB-aligned data
//   strb_c/wdata_c        : byte strobes and lane-replicated store data
//   misaligned_c          : request violates natural alignment
//   ld_funct3/ld_lo/ld_rdata : registered load attributes and bus read word
//   load_c                : shifted and sign/zero-extended load value
module dmem_lane
   import core_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lo,
   input  logic [31:0] st_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_lo,
   input  logic [31:0] ld_rdata,
   output logic [3:0]  strb_c,
   output logic [31:0] wdata_c,
   output logic        misaligned_c,
   output logic [31:0] load_c
);

   logic [31:0] shifted;

   // Store lanes: narrow data is replicated so any lane can pick it up
   always_comb begin
      strb_c  = 4'b1111;
      wdata_c = st_data;
      case (st_size)
         SZ_B: begin
            strb_c  = 4'b0001 << st_lo;
            wdata_c = {4{st_data[7:0]}};
         end
         SZ_H: begin
            strb_c  = 4'b0011 << st_lo;
            wdata_c = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Halfwords need an even address, words (including unused size 11) a 4-byte one
   assign misaligned_c = ((st_size == SZ_H) && st_lo[0]) ||
                         (st_size[1] && (st_lo != 2'b00));

   // Load: bring the addressed byte/half down to bit 0, then extend
   assign shifted = ld_rdata >> {ld_lo, 3'b000};

   always_comb begin
      load_c = shifted;
      case (ld_funct3)
         F3_B:    load_c = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_c = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_c = {24'd0, shifted[7:0]};
         F3_HU:   load_c = {16'd0, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage responder: turns an M-stage load/store into one req/ack bus
// transaction, freezes the pipeline meanwhile and returns extended load data.
//   clk, rst           : clock, synchronous active-high reset
//   i_m_*              : M-stage request (enables, funct3, address, store data)
//   o_m_memdata        : extended load data, valid while o_done
//   ex_stall           : pipeline freeze (combinational)
//   o_done/o_misalign/o_bus_err : one-cycle completion/status pulses
//   bus                : master side of the data bus
module dmem_bridge
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned AW      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_m_read_en,
   input  logic        i_m_write_en,
   input  logic [2:0]  i_m_funct3,
   input  logic [31:0] i_m_addr,
   input  logic [31:0] i_m_wdata,
   output logic [31:0] o_m_memdata,
   output logic        ex_stall,
   output logic        o_done,
   output logic        o_misalign,
   output logic        o_bus_err,
   dmem_bridge_if.master bus
);

   localparam int unsigned CW = 16;

   state_t        state_q, state_d;
   logic          req, misaligned, mis_pulse, accept, timeout_hit;
   logic [3:0]    lane_strb;
   logic [31:0]   lane_wdata, lane_load;

   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [1:0]    lo_q;
   logic [2:0]    f3_q;
   logic [31:0]   wdata_q;
   logic [3:0]    strb_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   memdata_q;
   logic          err_q;

   dmem_lane u_lane (
      .st_size      (i_m_funct3[1:0]),
      .st_lo        (i_m_addr[1:0]),
      .st_data      (i_m_wdata),
      .ld_funct3    (f3_q),
      .ld_lo        (lo_q),
      .ld_rdata     (bus.bus_rdata),
      .strb_c       (lane_strb),
      .wdata_c      (lane_wdata),
      .misaligned_c (misaligned),
      .load_c       (lane_load)
   );

   assign req         = i_m_read_en | i_m_write_en;
   assign mis_pulse   = (state_q == IDLE) && req && misaligned;
   assign accept      = (state_q == IDLE) && req && !misaligned;
   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   // Freeze until DONE; a rejected misaligned access never stalls
   assign ex_stall = req && (state_q != DONE) && !mis_pulse;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; ack wins over a simultaneous timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (bus.bus_ack || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture, timeout counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         lo_q      <= 2'b00;
         f3_q      <= 3'b000;
         wdata_q   <= '0;
         strb_q    <= 4'b0000;
         cnt_q     <= '0;
         memdata_q <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q    <= i_m_write_en;
                  addr_q  <= {i_m_addr[AW-1:2], 2'b00};
                  lo_q    <= i_m_addr[1:0];
                  f3_q    <= i_m_funct3;
                  wdata_q <= i_m_write_en ? lane_wdata : 32'd0;
                  strb_q  <= i_m_write_en ? lane_strb  : 4'b0000;
                  cnt_q   <= '0;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + CW'(1);
               if (bus.bus_ack) begin
                  memdata_q <= we_q ? 32'd0 : lane_load;
               end else if (timeout_hit) begin
                  memdata_q <= 32'd0;
                  err_q     <= 1'b1;
               end
            end
            DONE:    err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign o_m_memdata = memdata_q;
   assign o_done      = (state_q == DONE) || mis_pulse;
   assign o_misalign  = mis_pulse;
   assign o_bus_err   = err_q;

   assign bus.bus_req   = (state_q == BUSY);
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_wstrb = strb_q;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Responder for the core's memory-access stage.
- Accepts the M-stage load/store request: address = M result, store data = M rs2, plus read/write enables and funct3.
- Runs one transaction on a simple req/ack data bus and asserts ex_stall to freeze the pipeline until the access completes.
- Returns aligned, sign/zero-extended load data in time for the negedge M/W capture.

Parameters:
- TIMEOUT, 255, max cycles waiting for bus_ack before the access is aborted (1..65535)
- AW, 32, bus address width (≤32)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_m_read_en  in  1  M-stage load request
- i_m_write_en  in  1  M-stage store request
- i_m_funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use [1:0] only)
- i_m_addr  in  32  byte address
- i_m_wdata  in  32  store data, LSB-aligned
- o_m_memdata  out  32  extended load data, valid while o_done=1
- ex_stall  out  1  pipeline freeze
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  one-cycle pulse: misaligned access rejected
- o_bus_err  out  1  one-cycle pulse: timeout abort
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write
- bus_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte strobes
- bus_ack  in  1  slave completion; rdata valid same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Request: req = i_m_read_en | i_m_write_en. If both are set, the store takes priority.
- ex_stall = req & (state != DONE) & !(state==IDLE & misaligned). Purely combinational from state and inputs.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE:
  - req & misaligned: pulse o_misalign and o_done for one cycle, no bus cycle, ex_stall=0, remain IDLE.
  - req & aligned: register the request (addr, funct3, we, lane data, strobes) and go to BUSY.
- BUSY:
  - bus_req=1; bus fields come from registered copies, stable until ack.
  - bus_ack: capture bus_rdata (shifted by addr[1:0], extended per funct3), go to DONE.
  - Counter hits TIMEOUT-1 with no ack: drop bus_req, o_memdata=0, pulse o_bus_err, go to DONE.
- DONE (one cycle):
  - o_done=1, ex_stall=0, o_m_memdata holds the result, so the pipeline advances at the next posedge.
  - Next state is always IDLE, even if req is still high. The core presents the next instruction after the advance.
- Minimum request-to-done latency: 2 cycles (ack in the first BUSY cycle). A back-to-back access restarts from IDLE, so throughput is one access per 3 cycles.
- Strobes by stored size:
  - SB: 0001<<a[1:0], data replicated {4{b}}.
  - SH: 0011<<a[1:0], data {2{h}}.
  - SW: 1111.
  - Loads: strobes 0000.
- Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Undefined funct3 on a load is treated as LW.
- o_m_memdata holds its last value outside DONE (for stores it is 0 in DONE).
- Reset mid-BUSY: bus_req drops in the cycle after the reset edge; no o_done, no error pulse.
- bus_ack seen in IDLE or DONE is ignored.

Decomposition:
- Shared package (core_pkg):
  - funct3 size constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- Sub-module dmem_lane: combinational store strobe/data lane generation plus load shift/extension. Keeps the FSM file focused on sequencing.

Test Plan:
- LW at 0x100, slave acks after 3 cycles with 0xDEADBEEF -> bus_addr=0x100, wstrb=0000; ex_stall high 4 cycles; o_done with o_m_memdata=0xDEADBEEF.
- LB at 0x103, rdata 0x80FF_FFFF -> 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 with rdata 0xBEEF_0000 -> 0x0000BEEF.
- SH at 0x206, wdata 0x1234ABCD, immediate ack -> bus_addr=0x204, wstrb=1100, wdata=0xABCDABCD, bus_we=1; done 2 cycles after request.
- LW at 0x101 -> o_misalign and o_done pulse in the same cycle, bus_req never asserted, ex_stall stays 0.
- TIMEOUT=4 with no ack -> bus_req high exactly 4 cycles, then o_bus_err and o_done pulse with memdata=0; FSM back to IDLE.
- rst asserted in the 2nd BUSY cycle -> all outputs 0 next cycle; a later LW completes normally. Back-to-back SW then LW -> two separate bus cycles, DONE→IDLE gap verified.
